// File: rtl/multicycle_core_pkg.sv
// Shared encodings for the multi-cycle core: FSM states, ALU codes,
// register-destination and write-back selects, link register index.
// Pure constants; no logic, no latency, no flow control.
package multicycle_core_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_READ = 3'd1;
    localparam state_t ST_EXEC = 3'd2;
    localparam state_t ST_MEM  = 3'd3;
    localparam state_t ST_WB   = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;

    localparam logic [1:0] DST_RD   = 2'b00;
    localparam logic [1:0] DST_RT   = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;
    localparam logic [1:0] DST_NONE = 2'b11;

    localparam logic [1:0] WB_ALU     = 2'b00;
    localparam logic [1:0] WB_MEM     = 2'b01;
    localparam logic [1:0] WB_PC      = 2'b10;
    localparam logic [1:0] WB_ALU_ALT = 2'b11;

    // Link register is the highest-numbered register.
    function automatic int link_reg(input int reg_aw);
        return (1 << reg_aw) - 1;
    endfunction

endpackage

// File: rtl/multicycle_core_regfile.sv
// Register file: 2**REG_AW x WIDTH, two async read ports, one sync write port.
// Latency: reads combinational, write visible after the writing clock edge.
// Backpressure: none; R0 reads 0 and ignores writes, async active-low clear.
module core_regfile #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [WIDTH-1:0]  ra_dat,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [WIDTH-1:0]  rb_dat,
    input  logic              wr_vld,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_dat
);

    localparam int NREG = 2 ** REG_AW;

    logic [WIDTH-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_vld && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_dat;
        end
    end

    assign ra_dat = (ra_addr == '0) ? '0 : regs_q[ra_addr];
    assign rb_dat = (rb_addr == '0) ? '0 : regs_q[rb_addr];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core: regfile + ALU + data memory sequenced IDLE/READ/EXEC/(MEM)/WB.
// Latency: result/resultValid 3 cycles after accept (4 for memory ops).
// Backpressure: opReady high only in IDLE; inputs ignored while an op is in flight.
// Ports: CLK/RST_N; opValid/opReady handshake; Rd/Rt/Rs/imm/addedPC plus control
// bundle in; Da (R[Rs]), isZero, result, resultValid out.
module multicycle_core
    import multicycle_core_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              opValid,
    output logic              opReady,
    input  logic [REG_AW-1:0] Rd,
    input  logic [REG_AW-1:0] Rt,
    input  logic [REG_AW-1:0] Rs,
    input  logic [15:0]       imm,
    input  logic [WIDTH-1:0]  addedPC,
    input  logic [1:0]        RegDst,
    input  logic              RegWr,
    input  logic              MemWr,
    input  logic              ALUSrc,
    input  logic [1:0]        MemToReg,
    input  logic [2:0]        ALUCntrl,
    output logic [WIDTH-1:0]  Da,
    output logic              isZero,
    output logic [WIDTH-1:0]  result,
    output logic              resultValid
);

    localparam logic [REG_AW-1:0] LINK_REG = REG_AW'(link_reg(REG_AW));

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rs;
        logic [15:0]       imm;
        logic [WIDTH-1:0]  pc;
        logic [1:0]        regdst;
        logic              regwr;
        logic              memwr;
        logic              alusrc;
        logic [1:0]        memtoreg;
        logic [2:0]        aluctl;
    } op_t;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0]       ctl,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (ctl)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_SLT: return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            default: return '0;
        endcase
    endfunction

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] da_q, da_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             rvld_q, rvld_d;

    logic [WIDTH-1:0]  rf_a, rf_b;
    logic [WIDTH-1:0]  imm_sext;
    logic [WIDTH-1:0]  wb_val;
    logic              rf_wr_vld;
    logic [REG_AW-1:0] rf_wr_addr;
    logic [MEM_AW-1:0] mem_addr;
    logic [WIDTH-1:0]  mem [2**MEM_AW];
    logic [WIDTH-1:0]  mdata_q;

    core_regfile #(
        .WIDTH  (WIDTH),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk     (CLK),
        .rst_n   (RST_N),
        .ra_addr (op_q.rs),
        .ra_dat  (rf_a),
        .rb_addr (op_q.rt),
        .rb_dat  (rf_b),
        .wr_vld  (rf_wr_vld),
        .wr_addr (rf_wr_addr),
        .wr_dat  (wb_val)
    );

    assign imm_sext = WIDTH'($signed(op_q.imm));
    assign mem_addr = alu_q[MEM_AW-1:0];

    always_comb begin
        wb_val = alu_q;
        case (op_q.memtoreg)
            WB_MEM:             wb_val = mdata_q;
            WB_PC:              wb_val = op_q.pc;
            WB_ALU, WB_ALU_ALT: wb_val = alu_q;
            default:            wb_val = alu_q;
        endcase
    end

    always_comb begin
        rf_wr_addr = op_q.rd;
        case (op_q.regdst)
            DST_RT:   rf_wr_addr = op_q.rt;
            DST_LINK: rf_wr_addr = LINK_REG;
            default:  rf_wr_addr = op_q.rd;
        endcase
    end

    // Commit happens on the WB->IDLE edge, so the next op's READ sees it.
    assign rf_wr_vld = (state_q == ST_WB) && op_q.regwr && (op_q.regdst != DST_NONE);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        da_d     = da_q;
        zero_d   = zero_q;
        result_d = result_q;
        rvld_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (opValid) begin
                    op_d.rd       = Rd;
                    op_d.rt       = Rt;
                    op_d.rs       = Rs;
                    op_d.imm      = imm;
                    op_d.pc       = addedPC;
                    op_d.regdst   = RegDst;
                    op_d.regwr    = RegWr;
                    op_d.memwr    = MemWr;
                    op_d.alusrc   = ALUSrc;
                    op_d.memtoreg = MemToReg;
                    op_d.aluctl   = ALUCntrl;
                    state_d       = ST_READ;
                end
            end
            ST_READ: begin
                a_d     = rf_a;
                b_d     = rf_b;
                da_d    = rf_a;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                alu_d   = alu_fn(op_q.aluctl, a_q, op_q.alusrc ? imm_sext : b_q);
                zero_d  = (alu_d == '0);
                state_d = (op_q.memwr || (op_q.memtoreg == WB_MEM)) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                result_d = wb_val;
                rvld_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            da_q     <= '0;
            zero_q   <= 1'b0;
            result_q <= '0;
            rvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_q    <= alu_d;
            da_q     <= da_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            rvld_q   <= rvld_d;
        end
    end

    // Data memory is deliberately not reset. The read samples the old word
    // on the same edge a store overwrites it (read-before-write).
    always_ff @(posedge CLK) begin
        if (state_q == ST_MEM) begin
            if (op_q.memwr) begin
                mem[mem_addr] <= b_q;
            end
            mdata_q <= mem[mem_addr];
        end
    end

    assign opReady     = (state_q == ST_IDLE);
    assign Da          = da_q;
    assign isZero      = zero_q;
    assign result      = result_q;
    assign resultValid = rvld_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: directed steps plus random ops
// against a behavioural model of registers and memory.
// Drives inputs at negedge, samples outputs at negedge.
module tb_multicycle_core;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        opValid;
    logic        opReady;
    logic [4:0]  Rd, Rt, Rs;
    logic [15:0] imm;
    logic [31:0] addedPC;
    logic [1:0]  RegDst;
    logic        RegWr, MemWr, ALUSrc;
    logic [1:0]  MemToReg;
    logic [2:0]  ALUCntrl;
    logic [31:0] Da;
    logic        isZero;
    logic [31:0] result;
    logic        resultValid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [1024];

    always #5 CLK = ~CLK;

    multicycle_core #(.WIDTH(32), .REG_AW(5), .MEM_AW(10)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .opValid     (opValid),
        .opReady     (opReady),
        .Rd          (Rd),
        .Rt          (Rt),
        .Rs          (Rs),
        .imm         (imm),
        .addedPC     (addedPC),
        .RegDst      (RegDst),
        .RegWr       (RegWr),
        .MemWr       (MemWr),
        .ALUSrc      (ALUSrc),
        .MemToReg    (MemToReg),
        .ALUCntrl    (ALUCntrl),
        .Da          (Da),
        .isZero      (isZero),
        .result      (result),
        .resultValid (resultValid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op, predict it from the model, and check latency and outputs.
    task automatic run_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [15:0] im, input logic [31:0] pc,
                          input logic [1:0] rdst, input logic rwr, input logic mwr,
                          input logic asrc, input logic [1:0] m2r, input logic [2:0] ctl);
        logic [31:0] a, b, opb, alu, rdv, res;
        logic [9:0]  addr;
        logic [4:0]  dst;
        logic        memop, busy_bad;
        int          lat;
        a   = (rs == 5'd0) ? 32'd0 : m_regs[rs];
        b   = (rt == 5'd0) ? 32'd0 : m_regs[rt];
        opb = asrc ? {{16{im[15]}}, im} : b;
        case (ctl)
            3'd0:    alu = a + opb;
            3'd1:    alu = a - opb;
            3'd2:    alu = a ^ opb;
            3'd3:    alu = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            3'd4:    alu = a & opb;
            3'd5:    alu = a | opb;
            default: alu = 32'd0;
        endcase
        memop = mwr || (m2r == 2'b01);
        addr  = alu[9:0];
        rdv   = m_mem[addr];
        if (mwr) m_mem[addr] = b;
        res = (m2r == 2'b01) ? rdv : (m2r == 2'b10) ? pc : alu;
        if (rwr && rdst != 2'b11) begin
            dst = (rdst == 2'b00) ? rd : (rdst == 2'b01) ? rt : 5'd31;
            if (dst != 5'd0) m_regs[dst] = res;
        end

        @(negedge CLK);
        for (int k = 0; k < 10 && !opReady; k++) @(negedge CLK);
        chk("ready_before_issue", 32'(opReady), 32'd1);
        Rs = rs; Rt = rt; Rd = rd; imm = im; addedPC = pc; RegDst = rdst;
        RegWr = rwr; MemWr = mwr; ALUSrc = asrc; MemToReg = m2r; ALUCntrl = ctl;
        opValid = 1'b1;
        @(posedge CLK);
        #1 opValid = 1'b0;
        lat = 99;
        busy_bad = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(negedge CLK);
            if (resultValid) begin
                lat = k;
                break;
            end
            if (opReady) busy_bad = 1'b1;
        end
        chk("latency", 32'(lat), memop ? 32'd4 : 32'd3);
        chk("ready_while_busy", 32'(busy_bad), 32'd0);
        chk("result", result, res);
        chk("isZero", 32'(isZero), 32'(alu == 32'd0));
        chk("Da", Da, a);
        @(negedge CLK);
        chk("pulse_width", 32'(resultValid), 32'd0);
    endtask

    task automatic read_reg(input logic [4:0] r);
        run_op(r, 5'd0, 5'd0, 16'd0, 32'd0, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00, 3'd0);
    endtask

    task automatic addi(input logic [4:0] r, input logic [15:0] v);
        run_op(5'd0, r, 5'd0, v, 32'd0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 3'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_opReady"}, 32'(opReady), 32'd1);
        chk({tag, "_resultValid"}, 32'(resultValid), 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_Da"}, Da, 32'd0);
        chk({tag, "_isZero"}, 32'(isZero), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  rr, rt_r, rd_r;
        logic [1:0]  rdst_r, m2r_r;
        logic [15:0] im_r;

        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;
        RST_N = 1'b0; opValid = 1'b0;
        Rd = '0; Rt = '0; Rs = '0; imm = '0; addedPC = '0; RegDst = '0;
        RegWr = 1'b0; MemWr = 1'b0; ALUSrc = 1'b0; MemToReg = '0; ALUCntrl = '0;
        repeat (3) @(negedge CLK);
        chk_reset_state("rst_held");
        RST_N = 1'b1;
        @(negedge CLK);
        chk_reset_state("rst_released");

        // addi R1 = 5
        addi(5'd1, 16'h0005);
        chk("addi_result", result, 32'd5);
        chk("addi_isZero", 32'(isZero), 32'd0);

        // R-type on R20=25, R3=19 into R5
        addi(5'd20, 16'd25);
        addi(5'd3, 16'd19);
        run_op(5'd20, 5'd3, 5'd5, 16'd0, 32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0);
        read_reg(5'd5);
        chk("R5_add", Da, 32'd44);
        run_op(5'd20, 5'd3, 5'd5, 16'd0, 32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'd1);
        read_reg(5'd5);
        chk("R5_sub", Da, 32'd6);
        run_op(5'd20, 5'd3, 5'd5, 16'd0, 32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'd3);
        chk("slt_20_3", result, 32'd0);
        run_op(5'd3, 5'd20, 5'd5, 16'd0, 32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'd3);
        chk("slt_3_20", result, 32'd1);
        run_op(5'd20, 5'd20, 5'd5, 16'd0, 32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'd3);
        chk("slt_20_20", result, 32'd0);

        // SW R20 -> mem[R1+0], then LW R2
        run_op(5'd1, 5'd20, 5'd0, 16'd0, 32'd0, 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 3'd0);
        run_op(5'd1, 5'd2, 5'd0, 16'd0, 32'd0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 3'd0);
        chk("lw_result", result, 32'd25);

        // JAL to R31, then link write aimed at R0
        run_op(5'd0, 5'd0, 5'd0, 16'd0, 32'h19, 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, 3'd0);
        chk("jal_result", result, 32'h19);
        read_reg(5'd31);
        chk("R31_link", Da, 32'h19);
        run_op(5'd0, 5'd0, 5'd0, 16'd0, 32'h33, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 3'd0);
        read_reg(5'd0);
        chk("R0_zero", Da, 32'd0);

        // Branch compare
        addi(5'd16, 16'd16);
        addi(5'd17, 16'd17);
        run_op(5'd16, 5'd17, 5'd0, 16'd0, 32'd0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 3'd1);
        chk("bne_ne_isZero", 32'(isZero), 32'd0);
        addi(5'd16, 16'd15);
        addi(5'd17, 16'd15);
        run_op(5'd16, 5'd17, 5'd0, 16'd0, 32'd0, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 3'd1);
        chk("bne_eq_isZero", 32'(isZero), 32'd1);

        // Reserved ALU code writes 0; RegWr with RegDst=11 writes nothing
        run_op(5'd20, 5'd3, 5'd10, 16'd0, 32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'd6);
        run_op(5'd20, 5'd3, 5'd11, 16'd0, 32'd0, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0);

        // Random register contents, memory window 0..15 preloaded
        for (int i = 1; i < 32; i++) addi(5'(i), 16'($urandom));
        for (int i = 0; i < 16; i++)
            run_op(5'd0, 5'($urandom_range(1, 31)), 5'd0, 16'(i), 32'd0, 2'b11,
                   1'b0, 1'b1, 1'b1, 2'b00, 3'd0);

        for (int n = 0; n < 60; n++) begin
            rr     = 5'($urandom);
            rt_r   = 5'($urandom);
            rd_r   = 5'($urandom);
            rdst_r = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                // Upper imm bits exercise the ignored high address bits.
                im_r  = {6'($urandom), 6'd0, 4'($urandom)};
                m2r_r = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
                run_op(5'd0, rt_r, rd_r, im_r, $urandom, rdst_r, 1'($urandom),
                       (m2r_r == 2'b01) ? 1'($urandom) : 1'b1, 1'b1, m2r_r, 3'd0);
            end else begin
                case ($urandom_range(0, 2))
                    0:       m2r_r = 2'b00;
                    1:       m2r_r = 2'b10;
                    default: m2r_r = 2'b11;
                endcase
                run_op(rr, rt_r, rd_r, 16'($urandom), $urandom, rdst_r, 1'($urandom),
                       1'b0, 1'($urandom), m2r_r, 3'($urandom));
            end
        end

        // opValid held high: accepted only in IDLE, every 4 cycles
        @(negedge CLK);
        Rs = 5'd9; Rt = 5'd9; Rd = 5'd0; imm = 16'd1; addedPC = 32'd0; RegDst = 2'b01;
        RegWr = 1'b1; MemWr = 1'b0; ALUSrc = 1'b1; MemToReg = 2'b00; ALUCntrl = 3'd0;
        opValid = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge CLK);
            chk("held_opReady", 32'(opReady), 32'((j % 4) == 3));
            chk("held_resultValid", 32'(resultValid), 32'((j % 4) == 3));
        end
        opValid = 1'b0;
        m_regs[9] = m_regs[9] + 32'd3;
        chk("held_result", result, m_regs[9]);

        for (int i = 0; i < 32; i++) read_reg(5'(i));

        // Reset during EXEC of an add into R7
        addi(5'd7, 16'h0077);
        @(negedge CLK);
        Rs = 5'd7; Rt = 5'd7; Rd = 5'd7; RegDst = 2'b00; RegWr = 1'b1; MemWr = 1'b0;
        ALUSrc = 1'b0; MemToReg = 2'b00; ALUCntrl = 3'd0;
        opValid = 1'b1;
        @(posedge CLK);
        #1 opValid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk_reset_state("rst_mid");
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        @(negedge CLK);
        RST_N = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge CLK);
                if (resultValid) seen = 1'b1;
            end
            chk("rst_mid_no_pulse", 32'(seen), 32'd0);
        end
        read_reg(5'd7);
        chk("R7_after_reset", Da, 32'd0);
        // Memory survives reset
        run_op(5'd0, 5'd2, 5'd0, 16'd3, 32'd0, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
